// File: rtl/count_chk_pkg.sv
// Shared types and the next-count rule for the counter checker.
// The prediction function is used by the RTL predictor and by the bench.
package count_chk_pkg;

    // Monitor FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // Result of one predicted step: the next value mod 16, plus flags
    // telling whether the unmodded step left the 0..15 range.
    typedef struct packed {
        logic [3:0] next;
        logic       carry;
        logic       borrow;
    } pred_t;

    localparam int CNT_W = 4;

    // Next value of the monitored counter given its current sample.
    // A parity mismatch between p and the value's LSB means a +1 step
    // (p=1 with even c, or p=0 with odd c); otherwise f picks +2 or -2.
    function automatic pred_t predict_next(input logic [3:0] c,
                                           input logic       p,
                                           input logic       f);
        pred_t      r;
        logic [4:0] sum;
        r   = '0;
        sum = '0;
        if (p ^ c[0]) begin
            sum     = {1'b0, c} + 5'd1;
            r.carry = sum[4];
        end else if (f) begin
            sum     = {1'b0, c} + 5'd2;
            r.carry = sum[4];
        end else begin
            sum      = {1'b0, c} - 5'd2;
            r.borrow = (c < 4'd2);
        end
        r.next = sum[3:0];
        return r;
    endfunction

endpackage

// File: rtl/count_predict.sv
// Combinational next-count predictor wrapping the package rule.
module count_predict
    import count_chk_pkg::*;
(
    input  logic [3:0] c,
    input  logic       p,
    input  logic       f,
    output logic [3:0] next,
    output logic       carry,
    output logic       borrow
);

    pred_t pred;

    // Evaluate the shared prediction rule on the registered sample.
    always_comb begin
        pred   = predict_next(c, p, f);
        next   = pred.next;
        carry  = pred.carry;
        borrow = pred.borrow;
    end

endmodule

// File: rtl/count_checker.sv
// Monitors a 4-bit counter against its parity/direction stepping rule.
// A sample (count, p, f) is captured on every enabled edge; the next
// observed value is compared with the prediction made from that sample.
// Because the sample is always the observed value, a mismatch resyncs the
// prediction automatically.
module count_checker
    import count_chk_pkg::*;
#(
    parameter int FAULT_LIMIT = 3,   // consecutive mismatches to enter FAULT (1..15)
    parameter int ERR_W       = 8    // width of the saturating error counter
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             p_in,
    input  logic             f_in,
    input  logic [3:0]       count_in,
    output logic             locked,
    output logic             fault,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_up,
    output logic             wrap_dn
);

    localparam logic [3:0]       LIMIT   = 4'(FAULT_LIMIT);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_e           state_q, state_d;
    logic [3:0]       samp_c_q, samp_c_d;
    logic             samp_p_q, samp_p_d;
    logic             samp_f_q, samp_f_d;
    logic [3:0]       run_q, run_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             err_pulse_q, err_pulse_d;
    logic             wrap_up_q, wrap_up_d;
    logic             wrap_dn_q, wrap_dn_d;

    logic [3:0]       pred_next;
    logic             pred_carry;
    logic             pred_borrow;
    logic             compare_active;
    logic             mismatch;
    logic             matched;
    logic [3:0]       run_inc;
    logic             run_limit_hit;

    // Prediction is always taken from the previously captured sample.
    count_predict u_predict (
        .c      (samp_c_q),
        .p      (samp_p_q),
        .f      (samp_f_q),
        .next   (pred_next),
        .carry  (pred_carry),
        .borrow (pred_borrow)
    );

    // Comparison qualifiers: only TRACK and FAULT compare, and only when enabled.
    always_comb begin
        compare_active = en && ((state_q == ST_TRACK) || (state_q == ST_FAULT));
        mismatch       = compare_active && (count_in != pred_next);
        matched        = compare_active && (count_in == pred_next);
        run_inc        = (run_q == 4'hF) ? run_q : run_q + 4'd1;
        run_limit_hit  = mismatch && (run_inc >= LIMIT);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; dropping enable wins over everything else.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_SYNC;
                ST_SYNC:  state_d = ST_TRACK;
                ST_TRACK: if (run_limit_hit && !clr) state_d = ST_FAULT;
                ST_FAULT: if (clr) state_d = ST_SYNC;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output decode from the state register.
    always_comb begin
        locked = (state_q == ST_TRACK);
        fault  = (state_q == ST_FAULT);
    end

    // Next values for the sample, mismatch run, error counter and pulses.
    always_comb begin
        samp_c_d    = samp_c_q;
        samp_p_d    = samp_p_q;
        samp_f_d    = samp_f_q;
        run_d       = run_q;
        err_count_d = err_count_q;
        err_pulse_d = mismatch;
        wrap_up_d   = matched && pred_carry;
        wrap_dn_d   = matched && pred_borrow;

        // Capture the observed value so the next prediction follows it.
        if (en) begin
            samp_c_d = count_in;
            samp_p_d = p_in;
            samp_f_d = f_in;
        end

        // Run of consecutive mismatches; anything but a mismatch resets it.
        if (clr || !compare_active || !mismatch) begin
            run_d = 4'd0;
        end else begin
            run_d = run_inc;
        end

        // Clear has priority over a coincident mismatch; the count never wraps.
        if (clr) begin
            err_count_d = '0;
        end else if (mismatch && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_c_q    <= '0;
            samp_p_q    <= 1'b0;
            samp_f_q    <= 1'b0;
            run_q       <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            wrap_up_q   <= 1'b0;
            wrap_dn_q   <= 1'b0;
        end else begin
            samp_c_q    <= samp_c_d;
            samp_p_q    <= samp_p_d;
            samp_f_q    <= samp_f_d;
            run_q       <= run_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            wrap_up_q   <= wrap_up_d;
            wrap_dn_q   <= wrap_dn_d;
        end
    end

    // Registered flags straight to the ports.
    always_comb begin
        err_count = err_count_q;
        err_pulse = err_pulse_q;
        wrap_up   = wrap_up_q;
        wrap_dn   = wrap_dn_q;
    end

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker with hand-computed expectations.
module tb_count_checker;
    import count_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       p_in;
    logic       f_in;
    logic [3:0] count_in;
    logic       locked;
    logic       fault;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       wrap_up;
    logic       wrap_dn;

    int passed = 0;
    int total  = 0;

    count_checker #(.FAULT_LIMIT(3), .ERR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .p_in      (p_in),
        .f_in      (f_in),
        .count_in  (count_in),
        .locked    (locked),
        .fault     (fault),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Present one count value and let one rising edge take it.
    task automatic step(input logic [3:0] c);
        count_in = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; p_in = 1'b0; f_in = 1'b0; count_in = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_errcnt", 32'(err_count), 0);
        check("rst_pulse", 32'(err_pulse), 0);
        #3 rst_n = 1'b1;

        // Scenario 1: legal stream 0,1,3,5,7 with p=1 f=1.
        en = 1'b1; p_in = 1'b1; f_in = 1'b1;
        step(4'd0);  check("s1_sync_lock", 32'(locked), 0);
        step(4'd1);  check("s1_track_lock", 32'(locked), 1);
        step(4'd3);  check("s1_pulse3", 32'(err_pulse), 0);
        step(4'd5);
        step(4'd7);  check("s1_errcnt", 32'(err_count), 0);

        // Scenario 2: continue to 13,15,1 -> one carry on 15->1.
        step(4'd9);
        step(4'd11);
        step(4'd13);
        step(4'd15); check("s2_wrap_15", 32'(wrap_up), 0);
        step(4'd1);  check("s2_wrap_1", 32'(wrap_up), 1);
        check("s2_pulse_1", 32'(err_pulse), 0);
        step(4'd3);  check("s2_wrap_3", 32'(wrap_up), 0);

        // Scenario 3: p=0 f=0, ... 2,0,14 -> one borrow on 0->14.
        p_in = 1'b0; f_in = 1'b0;
        step(4'd5);
        step(4'd6);
        step(4'd4);
        step(4'd2);
        step(4'd0);  check("s3_wrapdn_0", 32'(wrap_dn), 0);
        step(4'd14); check("s3_wrapdn_14", 32'(wrap_dn), 1);
        step(4'd12); check("s3_wrapdn_12", 32'(wrap_dn), 0);
        check("s3_errcnt", 32'(err_count), 0);

        // Scenario 4: three wrong values (predictions 10, 4, 4) -> FAULT.
        step(4'd3);  check("s4_pulse1", 32'(err_pulse), 1);
        step(4'd3);  check("s4_cnt2", 32'(err_count), 2);
        check("s4_notfault2", 32'(fault), 0);
        step(4'd3);  check("s4_cnt3", 32'(err_count), 3);
        check("s4_fault", 32'(fault), 1);
        check("s4_unlocked", 32'(locked), 0);
        // clr together with a mismatch: count cleared, pulse still fires, SYNC.
        clr = 1'b1;
        step(4'd3);  check("s4_clr_cnt", 32'(err_count), 0);
        check("s4_clr_pulse", 32'(err_pulse), 1);
        check("s4_clr_fault", 32'(fault), 0);
        check("s4_clr_lock", 32'(locked), 0);
        clr = 1'b0;
        step(4'd3);  check("s4_sync_pulse", 32'(err_pulse), 0);
        check("s4_relock", 32'(locked), 1);
        step(4'd4);  check("s4_match", 32'(err_pulse), 0);

        // A match in between breaks the mismatch run.
        step(4'd9);
        step(4'd9);
        step(4'd10); check("run_match", 32'(err_pulse), 0);
        step(4'd10);
        step(4'd10); check("run_nofault", 32'(fault), 0);
        check("run_cnt4", 32'(err_count), 4);
        step(4'd10); check("run_fault", 32'(fault), 1);
        check("run_cnt5", 32'(err_count), 5);

        // Scenario 5: keep mismatching in FAULT up to saturation.
        for (int i = 0; i < 250; i++) step(4'd10);
        check("s5_cnt255", 32'(err_count), 255);
        step(4'd10); check("s5_sat", 32'(err_count), 255);
        check("s5_pulse", 32'(err_pulse), 1);

        // Scenario 6: asynchronous reset in the middle of a TRACK cycle.
        clr = 1'b1;
        step(4'd10); check("s6_clr", 32'(err_count), 0);
        clr = 1'b0; p_in = 1'b1; f_in = 1'b1;
        step(4'd15);
        step(4'd2);
        step(4'd15);
        step(4'd1);  check("s6_wrap", 32'(wrap_up), 1);
        check("s6_cnt2", 32'(err_count), 2);
        check("s6_lock", 32'(locked), 1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_ar_lock", 32'(locked), 0);
        check("s6_ar_wrap", 32'(wrap_up), 0);
        check("s6_ar_cnt", 32'(err_count), 0);
        #2 rst_n = 1'b1;
        step(4'd6);  check("s6_idle_pulse", 32'(err_pulse), 0);
        check("s6_idle_lock", 32'(locked), 0);
        step(4'd0);  check("s6_sync_pulse", 32'(err_pulse), 0);
        check("s6_sync_lock", 32'(locked), 1);
        step(4'd0);  check("s6_cmp_pulse", 32'(err_pulse), 1);
        check("s6_cmp_cnt", 32'(err_count), 1);

        // Dropping enable returns to IDLE without touching the count.
        en = 1'b0;
        step(4'd0);  check("en0_lock", 32'(locked), 0);
        check("en0_pulse", 32'(err_pulse), 0);
        check("en0_cnt", 32'(err_count), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
